mem_lane_adapter: RTL and testbench



---
 rtl/mem_lane_adapter.sv | 170 +++++++++++++++++
 tb/tb_mem_lane_adapter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lane_adapter.sv
// -----------------------------------------------------------------------------
// mem_lane_adapter
//
// Purpose:
//   32-bit valid/ready request/response adapter in front of one port of a
//   40-bit RAM. Each data byte is stored in a 10-bit lane as
//   {1'b0, even_parity(byte), byte}. Reads are checked for parity on return.
//   Responses go through a small FIFO so the requester can apply backpressure.
//
// Ports:
//   clk_i, rstn_i              clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  request handshake
//   req_addr_i, req_wdata_i    word address, write data
//   req_be_i, req_we_i         byte enables (writes only), 1 = write
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_rdata_o                read data (0 for write responses)
//   rsp_write_o                response belongs to a write
//   rsp_err_o                  parity error seen on the read data
//   ram_addr_o, ram_din_o      RAM address, packed write data
//   ram_be_o                   RAM lane strobes
//   ram_wren_o, ram_rden_o     RAM write / read enables
//   ram_dout_i                 RAM read data, valid one cycle after rden
// -----------------------------------------------------------------------------
module mem_lane_adapter #(
    parameter int AddrWidth = 10,
    parameter int DataWidth = 32,
    parameter int RamWidth  = 40,
    parameter int BeWidth   = 4,
    parameter int RspDepth  = 3
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    input  logic                 req_we_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_write_o,
    output logic                 rsp_err_o,
    output logic [AddrWidth-1:0] ram_addr_o,
    output logic [RamWidth-1:0]  ram_din_o,
    output logic [BeWidth-1:0]   ram_be_o,
    output logic                 ram_wren_o,
    output logic                 ram_rden_o,
    input  logic [RamWidth-1:0]  ram_dout_i
);

    localparam int LaneW = RamWidth / BeWidth;
    localparam int CntW  = $clog2(RspDepth + 1);
    localparam int PtrW  = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    typedef struct packed {
        logic                 write;
        logic                 err;
        logic [DataWidth-1:0] rdata;
    } rsp_t;

    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [CntW-1:0]      count;
    logic [CntW:0]        occupancy;
    logic                 inflight;
    logic                 inflight_we;
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    rsp_t                 fifo_mem [RspDepth];
    rsp_t                 cap_entry;
    rsp_t                 head;
    logic                 unused_lane_msbs;

    // Every in-flight request already owns a FIFO slot, so the ready rule
    // only looks at registered state and never at rsp_ready_i.
    assign occupancy   = {1'b0, count} + {{CntW{1'b0}}, inflight};
    assign req_ready_o = rstn_i & (occupancy < (CntW+1)'(RspDepth));
    assign accept      = req_valid_i & req_ready_o;

    // RAM drive: combinational from the request during the accept cycle only.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        ram_addr_o = '0;
        ram_din_o  = '0;
        ram_be_o   = '0;
        ram_wren_o = 1'b0;
        ram_rden_o = 1'b0;
        if (accept) begin
            ram_addr_o = req_addr_i;
            if (req_we_i) begin
                ram_wren_o = 1'b1;
                ram_be_o   = req_be_i;
                for (int i = 0; i < BeWidth; i++) begin
                    ram_din_o[i*LaneW +: LaneW] =
                        LaneW'({^req_wdata_i[i*8 +: 8], req_wdata_i[i*8 +: 8]});
                end
            end else begin
                ram_rden_o = 1'b1;
            end
        end
    end

    // Capture: unpack read lanes and check parity over data + parity bits.
    always_comb begin
        cap_entry = '0;
        if (inflight_we) begin
            cap_entry.write = 1'b1;
        end else begin
            for (int i = 0; i < BeWidth; i++) begin
                cap_entry.rdata[i*8 +: 8] = ram_dout_i[i*LaneW +: 8];
                cap_entry.err = cap_entry.err | (^ram_dout_i[i*LaneW +: 9]);
            end
        end
    end

    // Lane bit 9 is always written as 0 and carries no information on read.
    always_comb begin
        unused_lane_msbs = 1'b0;
        for (int i = 0; i < BeWidth; i++) begin
            unused_lane_msbs = unused_lane_msbs ^ ram_dout_i[i*LaneW + LaneW - 1];
        end
    end

    assign push = inflight;
    assign pop  = rsp_valid_o & rsp_ready_i;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count       <= '0;
            inflight    <= 1'b0;
            inflight_we <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            inflight    <= accept;
            inflight_we <= accept & req_we_i;
            if (push) begin
                wr_ptr <= (wr_ptr == PtrW'(RspDepth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PtrW'(RspDepth - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: FIFO storage is deliberately not reset; count decides which
    // entries are valid, and outputs are gated while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cap_entry;
        end
    end

    assign head        = fifo_mem[rd_ptr];
    assign rsp_valid_o = (count != '0);
    assign rsp_rdata_o = rsp_valid_o ? head.rdata : '0;
    assign rsp_write_o = rsp_valid_o & head.write;
    assign rsp_err_o   = rsp_valid_o & head.err;

endmodule

// File: tb/tb_mem_lane_adapter.sv
// -----------------------------------------------------------------------------
// tb_mem_lane_adapter
//
// Bench for mem_lane_adapter with a behavioural 40-bit RAM (lane strobes,
// one-cycle read latency, optional lane-2 parity corruption) and a 32-bit
// reference memory. Expected responses are queued at acceptance and compared
// when the adapter hands them over.
// -----------------------------------------------------------------------------
module tb_mem_lane_adapter;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [9:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        req_we_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_write_o;
    logic        rsp_err_o;
    logic [9:0]  ram_addr_o;
    logic [39:0] ram_din_o;
    logic [3:0]  ram_be_o;
    logic        ram_wren_o;
    logic        ram_rden_o;
    logic [39:0] ram_dout_i = '0;

    always #5 clk_i = ~clk_i;

    mem_lane_adapter dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .req_we_i    (req_we_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_write_o (rsp_write_o),
        .rsp_err_o   (rsp_err_o),
        .ram_addr_o  (ram_addr_o),
        .ram_din_o   (ram_din_o),
        .ram_be_o    (ram_be_o),
        .ram_wren_o  (ram_wren_o),
        .ram_rden_o  (ram_rden_o),
        .ram_dout_i  (ram_dout_i)
    );

    // Behavioural RAM: lane-strobed writes, registered reads.
    logic [39:0] ram_mem [1024];
    bit          corrupt = 1'b0;

    always @(posedge clk_i) begin
        if (ram_wren_o) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be_o[i]) ram_mem[ram_addr_o][i*10 +: 10] <= ram_din_o[i*10 +: 10];
            end
        end
        if (ram_rden_o) begin
            // Flip lane 2's parity bit (bit 28) when corruption is requested.
            ram_dout_i <= ram_mem[ram_addr_o] ^ (corrupt ? 40'h00_1000_0000 : 40'h0);
        end
    end

    typedef struct {
        logic        write;
        logic        err;
        logic [31:0] rdata;
        int          acc_cyc;
        bit          lat_en;
    } exp_t;

    exp_t        sb [$];
    exp_t        mon_e;
    logic [31:0] ref_mem [1024];
    int          cyc     = 0;
    int          passed  = 0;
    int          total   = 0;
    int          acc_cnt = 0;
    int          stalls  = 0;
    bit          lat_en  = 1'b0;

    logic [39:0] last_din;
    logic [3:0]  last_be;
    logic        last_wren;
    logic        last_rden;
    logic [9:0]  last_addr;

    always @(posedge clk_i) cyc++;

    // Scoreboard monitor: push at acceptance, pop/compare at handover.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (req_valid_i && req_ready_o) begin
                mon_e.acc_cyc = cyc;
                mon_e.lat_en  = lat_en;
                if (req_we_i) begin
                    for (int i = 0; i < 4; i++) begin
                        if (req_be_i[i]) ref_mem[req_addr_i][i*8 +: 8] = req_wdata_i[i*8 +: 8];
                    end
                    mon_e.write = 1'b1;
                    mon_e.err   = 1'b0;
                    mon_e.rdata = '0;
                end else begin
                    mon_e.write = 1'b0;
                    mon_e.err   = corrupt;
                    mon_e.rdata = ref_mem[req_addr_i];
                end
                sb.push_back(mon_e);
                acc_cnt++;
            end
            if (rsp_valid_o && rsp_ready_i) begin
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL rsp_unexpected: got write=%b err=%b rdata=%h, required no response",
                             rsp_write_o, rsp_err_o, rsp_rdata_o);
                end else begin
                    mon_e = sb.pop_front();
                    if (rsp_write_o !== mon_e.write || rsp_err_o !== mon_e.err ||
                        rsp_rdata_o !== mon_e.rdata) begin
                        $display("FAIL rsp_data: got write=%b err=%b rdata=%h, required write=%b err=%b rdata=%h",
                                 rsp_write_o, rsp_err_o, rsp_rdata_o,
                                 mon_e.write, mon_e.err, mon_e.rdata);
                    end else begin
                        passed++;
                    end
                    if (mon_e.lat_en) begin
                        total++;
                        if ((cyc - mon_e.acc_cyc) !== 2) begin
                            $display("FAIL rsp_latency: got %0d cycles, required 2", cyc - mon_e.acc_cyc);
                        end else begin
                            passed++;
                        end
                    end
                end
            end
        end
    end

    // Drive one request and hold it until accepted; returns just after the
    // edge that ends the accept cycle, with the request still driven.
    task automatic send(input logic we, input logic [9:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        int waited = 0;
        bit done   = 1'b0;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_be_i    = be;
        while (!done) begin
            @(negedge clk_i);
            if (req_ready_o) begin
                done      = 1'b1;
                last_din  = ram_din_o;
                last_be   = ram_be_o;
                last_wren = ram_wren_o;
                last_rden = ram_rden_o;
                last_addr = ram_addr_o;
            end else begin
                waited++;
                stalls++;
                if (waited > 100) begin
                    total++;
                    $display("FAIL send_timeout: got no accept after %0d cycles, required accept", waited);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_be_i    = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || rsp_valid_o) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        total++;
        if (sb.size() != 0 || rsp_valid_o !== 1'b0) begin
            $display("FAIL drain: got %0d pending, rsp_valid=%b, required 0 pending", sb.size(), rsp_valid_o);
        end else begin
            passed++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 10'h3FF;
        req_wdata_i = 32'hFFFF_FFFF;
        req_be_i    = 4'hF;
        rstn_i      = 1'b0;
        repeat (2) @(negedge clk_i);
        total++;
        if (req_ready_o !== 1'b0) $display("FAIL reset_ready: got %b, required 0", req_ready_o);
        else passed++;
        total++;
        if ({rsp_valid_o, rsp_write_o, rsp_err_o, rsp_rdata_o} !== 35'h0)
            $display("FAIL reset_rsp: got valid=%b write=%b err=%b rdata=%h, required all 0",
                     rsp_valid_o, rsp_write_o, rsp_err_o, rsp_rdata_o);
        else passed++;
        total++;
        if ({ram_wren_o, ram_rden_o, ram_be_o, ram_addr_o, ram_din_o} !== 56'h0)
            $display("FAIL reset_ram: got wren=%b rden=%b be=%h addr=%h din=%h, required all 0",
                     ram_wren_o, ram_rden_o, ram_be_o, ram_addr_o, ram_din_o);
        else passed++;
        idle();
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        #1;
        total++;
        if (req_ready_o !== 1'b1) $display("FAIL release_ready: got %b, required 1", req_ready_o);
        else passed++;
    endtask

    task automatic test_write_read();
        rsp_ready_i = 1'b1;
        lat_en      = 1'b1;
        send(1'b1, 10'h005, 32'hA5C3_0F81, 4'hF);
        total++;
        // Lanes: {0,0,A5}{0,0,C3}{0,0,0F}{0,0,81} -- all four bytes have even weight.
        if (last_din !== 40'h29_4C30_3C81 || last_wren !== 1'b1 || last_be !== 4'hF)
            $display("FAIL write_din: got din=%h wren=%b be=%h, required din=294c303c81 wren=1 be=f",
                     last_din, last_wren, last_be);
        else passed++;
        send(1'b0, 10'h005, 32'h0, 4'hF);
        total++;
        if (last_rden !== 1'b1 || last_wren !== 1'b0 || last_be !== 4'h0 || last_addr !== 10'h005)
            $display("FAIL read_drive: got rden=%b wren=%b be=%h addr=%h, required rden=1 wren=0 be=0 addr=005",
                     last_rden, last_wren, last_be, last_addr);
        else passed++;
        idle();
        #1;
        total++;
        if ({ram_wren_o, ram_rden_o, ram_be_o, ram_addr_o, ram_din_o} !== 56'h0)
            $display("FAIL idle_ram: got wren=%b rden=%b be=%h addr=%h din=%h, required all 0",
                     ram_wren_o, ram_rden_o, ram_be_o, ram_addr_o, ram_din_o);
        else passed++;
        wait_drain();
    endtask

    task automatic test_partial_write();
        lat_en = 1'b1;
        send(1'b1, 10'h005, 32'h0000_00FF, 4'h1);
        total++;
        if (last_be !== 4'h1 || last_wren !== 1'b1)
            $display("FAIL partial_be: got be=%h wren=%b, required be=1 wren=1", last_be, last_wren);
        else passed++;
        send(1'b0, 10'h005, 32'h0, 4'h0);
        idle();
        wait_drain();
    endtask

    task automatic test_parity_error();
        lat_en  = 1'b1;
        corrupt = 1'b1;
        send(1'b0, 10'h005, 32'h0, 4'h0);
        corrupt = 1'b0;
        idle();
        wait_drain();
    endtask

    task automatic test_backpressure();
        int          acc0;
        int          rdy_seen = 0;
        logic [31:0] held;
        rsp_ready_i = 1'b1;
        lat_en      = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b1, 10'(10'h040 + i), 32'h1111_0000 + 32'(i * 32'h0101_0101), 4'hF);
        idle();
        wait_drain();
        rsp_ready_i = 1'b0;
        acc0 = acc_cnt;
        for (int i = 0; i < 3; i++) send(1'b0, 10'(10'h040 + i), 32'h0, 4'h0);
        req_addr_i = 10'h043;
        @(negedge clk_i);
        held = rsp_rdata_o;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (req_ready_o) rdy_seen++;
        end
        total++;
        if (rdy_seen !== 0) $display("FAIL bp_ready: got ready high %0d cycles, required 0", rdy_seen);
        else passed++;
        total++;
        if ((acc_cnt - acc0) !== 3) $display("FAIL bp_accepts: got %0d, required 3", acc_cnt - acc0);
        else passed++;
        total++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== held)
            $display("FAIL bp_hold: got valid=%b rdata=%h, required valid=1 rdata=%h", rsp_valid_o, rsp_rdata_o, held);
        else passed++;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b1;
        send(1'b0, 10'h043, 32'h0, 4'h0);
        send(1'b0, 10'h044, 32'h0, 4'h0);
        idle();
        wait_drain();
        total++;
        if ((acc_cnt - acc0) !== 5) $display("FAIL bp_total: got %0d, required 5", acc_cnt - acc0);
        else passed++;
    endtask

    task automatic test_streaming();
        int acc0;
        rsp_ready_i = 1'b1;
        lat_en      = 1'b1;
        stalls      = 0;
        acc0        = acc_cnt;
        for (int i = 0; i < 16; i++) begin
            send(i[0] == 1'b0, 10'(10'h020 + (i / 2) % 4), $urandom, 4'($urandom_range(0, 15)));
        end
        idle();
        total++;
        if (stalls !== 0) $display("FAIL stream_ready: got %0d stall cycles, required 0", stalls);
        else passed++;
        total++;
        if ((acc_cnt - acc0) !== 16) $display("FAIL stream_accepts: got %0d, required 16", acc_cnt - acc0);
        else passed++;
        wait_drain();
    endtask

    task automatic test_mid_reset();
        int stale = 0;
        rsp_ready_i = 1'b0;
        lat_en      = 1'b0;
        send(1'b0, 10'h040, 32'h0, 4'h0);
        send(1'b0, 10'h041, 32'h0, 4'h0);
        send(1'b0, 10'h042, 32'h0, 4'h0);
        idle();
        rstn_i = 1'b0;
        sb.delete();
        #1;
        total++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0)
            $display("FAIL midreset_drop: got valid=%b ready=%b, required 0 0", rsp_valid_o, req_ready_o);
        else passed++;
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) stale++;
        end
        total++;
        if (stale !== 0) $display("FAIL midreset_stale: got %0d valid cycles, required 0", stale);
        else passed++;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b1;
        lat_en      = 1'b1;
        send(1'b0, 10'h041, 32'h0, 4'h0);
        idle();
        wait_drain();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        rstn_i      = 1'b1;
        rsp_ready_i = 1'b0;
        idle();
        #1;
        test_reset();
        test_write_read();
        test_partial_write();
        test_parity_error();
        test_backpressure();
        test_streaming();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
